// File: rtl/integral_window_ctrl.sv
// Streams one WIN_W x WIN_H grayscale window in raster order and emits its
// summed-area (integral) image, one registered write per accepted pixel.
module integral_window_ctrl #(
    parameter  int WIN_W = 20,
    parameter  int WIN_H = 20,
    parameter  int PIX_W = 8,
    parameter  int ACC_W = 32,
    localparam int AW    = (WIN_W * WIN_H > 1) ? $clog2(WIN_W * WIN_H) : 1,
    localparam int CW    = (WIN_W > 1) ? $clog2(WIN_W) : 1,
    localparam int RW    = (WIN_H > 1) ? $clog2(WIN_H) : 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    output logic             ii_we,
    output logic [AW-1:0]    ii_addr,
    output logic [ACC_W-1:0] ii_wdata,
    output logic             row_done,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;

    state_e           state_q;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic [AW-1:0]    idx_q;
    logic [ACC_W-1:0] rowsum_q;
    logic [ACC_W-1:0] prev_q [WIN_W];
    logic             we_q, rdone_q;
    logic [AW-1:0]    addr_q;
    logic [ACC_W-1:0] wdata_q;

    logic             acc;
    logic             last_col, last_row;
    logic [ACC_W-1:0] rowsum_d, value_d;

    // Abort masks the handshake so a pixel offered in the abort cycle is never written.
    assign pix_ready = (state_q == S_LOAD) && !abort;
    assign acc       = pix_valid && pix_ready;
    assign last_col  = (col_q == CW'(WIN_W - 1));
    assign last_row  = (row_q == RW'(WIN_H - 1));

    always_comb begin
        rowsum_d = ((col_q == '0) ? '0 : rowsum_q) + ACC_W'(pix_data);
        value_d  = rowsum_d + ((row_q == '0) ? '0 : prev_q[col_q]);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            idx_q    <= '0;
            rowsum_q <= '0;
            for (int i = 0; i < WIN_W; i++) prev_q[i] <= '0;
            we_q     <= 1'b0;
            rdone_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            we_q    <= acc;
            rdone_q <= acc && last_col;
            if (acc) begin
                addr_q        <= idx_q;
                wdata_q       <= value_d;
                rowsum_q      <= rowsum_d;
                prev_q[col_q] <= value_d;
                idx_q         <= idx_q + 1'b1;
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            if (abort) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        state_q  <= S_LOAD;
                        col_q    <= '0;
                        row_q    <= '0;
                        idx_q    <= '0;
                        rowsum_q <= '0;
                    end
                    S_LOAD:  if (acc && last_col && last_row) state_q <= S_FLUSH;
                    S_FLUSH: state_q <= S_DONE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ii_we    = we_q;
    assign ii_addr  = addr_q;
    assign ii_wdata = wdata_q;
    assign row_done = rdone_q;
    assign busy     = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_integral_window_ctrl.sv
// Directed bench for integral_window_ctrl: full windows checked against a
// brute-force integral-image model, plus abort, reset and ignored-start cases.
module tb_integral_window_ctrl;

    localparam int W  = 20;
    localparam int H  = 20;
    localparam int N  = W * H;
    localparam int AW = 9;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, pix_valid = 1'b0;
    logic [7:0]    pix_data = '0;
    logic          pix_ready, ii_we, row_done, busy, done;
    logic [AW-1:0] ii_addr;
    logic [31:0]   ii_wdata;

    integral_window_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .ii_we(ii_we), .ii_addr(ii_addr), .ii_wdata(ii_wdata),
        .row_done(row_done), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int wr_cnt, rd_cnt, done_cnt, done_cyc, wr_last_cyc;
    logic [31:0] mem [N];
    bit   lat_en = 1'b0;
    bit   prev_acc = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] pix(input int mode, input int r, input int c);
        case (mode)
            0:       return 32'd1;
            1:       return 32'(c + 1);
            default: return 32'd255;
        endcase
    endfunction

    function automatic logic [31:0] model(input int mode, input int r, input int c);
        logic [31:0] s = '0;
        for (int i = 0; i <= r; i++)
            for (int j = 0; j <= c; j++) s += pix(mode, i, j);
        return s;
    endfunction

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (ii_we) begin
            wr_cnt++;
            if (int'(ii_addr) < N) mem[ii_addr] = ii_wdata;
            if (int'(ii_addr) == N - 1) wr_last_cyc = cyc;
            if (row_done) rd_cnt++;
        end
        chk("row_done_align", row_done, ii_we && (int'(ii_addr) % W == W - 1));
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (lat_en) chk("write_follows_accept", ii_we, prev_acc);
        prev_acc = pix_valid && pix_ready;
    end

    task automatic clear_log();
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; done_cyc = -1; wr_last_cyc = -100;
        for (int i = 0; i < N; i++) mem[i] = 'x;
    endtask

    task automatic begin_window();
        clear_log();
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int mode, input bit tog, input int npix, input int start_at);
        int  n = 0, budget = 0;
        bit  ph = 1'b1, a;
        while (n < npix && budget < 3000) begin
            pix_valid = tog ? ph : 1'b1;
            ph        = !ph;
            pix_data  = 8'(pix(mode, n / W, n % W));
            start     = (n == start_at);
            a         = pix_valid && pix_ready;
            @(posedge Clk); #1;
            budget++;
            if (a) n++;
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        chk("pixels_accepted", n, npix);
    endtask

    task automatic check_window(input int mode);
        int t = 0;
        while (done_cnt == 0 && t < 20) begin
            @(posedge Clk); #1;
            t++;
        end
        chk("write_count", wr_cnt, N);
        chk("row_done_count", rd_cnt, H);
        chk("done_count", done_cnt, 1);
        chk("done_after_last_write", done_cyc, wr_last_cyc + 1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                chk($sformatf("ii[%0d][%0d]", r, c), mem[r * W + c], model(mode, r, c));
        repeat (2) @(posedge Clk);
        #1 chk("idle_after_window", busy, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_pix_ready"}, pix_ready, 0);
        chk({tag, "_ii_we"},     ii_we, 0);
        chk({tag, "_ii_addr"},   ii_addr, 0);
        chk({tag, "_ii_wdata"},  ii_wdata, 0);
        chk({tag, "_row_done"},  row_done, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_done"},      done, 0);
    endtask

    initial begin
        clear_log();
        #12 chk_outputs_zero("reset");
        @(posedge Clk); #1 Reset_n = 1'b1;
        @(posedge Clk); #1;

        // All-ones window
        begin_window();
        chk("busy_in_load", busy, 1'b1);
        feed(0, 1'b0, N, -1);
        check_window(0);
        chk("ones_addr0", mem[0], 32'd1);
        chk("ones_addr19", mem[19], 32'd20);
        chk("ones_addr20", mem[20], 32'd2);
        chk("ones_addr399", mem[399], 32'd400);

        // Ramp with pix_valid toggling; every cycle's write must track the previous accept
        lat_en = 1'b1;
        begin_window();
        feed(1, 1'b1, N, -1);
        check_window(1);
        lat_en = 1'b0;
        chk("ramp_addr399", mem[399], 32'd4200);

        // Saturated pixels
        begin_window();
        feed(2, 1'b0, N, -1);
        check_window(2);
        chk("max_addr399", mem[399], 32'd102000);

        // Abort after 150 pixels; the 150th write lands in the abort cycle
        begin_window();
        feed(0, 1'b0, 150, -1);
        abort = 1'b1;
        @(posedge Clk); #1;
        abort     = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 8'd1;
        repeat (10) @(posedge Clk);
        #1;
        pix_valid = 1'b0;
        chk("abort_write_count", wr_cnt, 150);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_pix_ready", pix_ready, 1'b0);
        begin_window();
        feed(0, 1'b0, N, -1);
        check_window(0);
        chk("post_abort_addr0", mem[0], 32'd1);

        // Asynchronous reset in row 7
        begin_window();
        feed(0, 1'b0, 150, -1);
        pix_valid = 1'b1;
        pix_data  = 8'd1;
        #2 Reset_n = 1'b0;
        #1 chk_outputs_zero("midrow_reset");
        @(posedge Clk); #1;
        chk("reset_held_busy", busy, 1'b0);
        Reset_n   = 1'b1;
        pix_valid = 1'b0;
        @(posedge Clk); #1;
        begin_window();
        feed(0, 1'b0, N, -1);
        check_window(0);
        chk("post_reset_addr399", mem[399], 32'd400);

        // start+abort in IDLE, then stray starts in LOAD, FLUSH and DONE
        start = 1'b1;
        abort = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", busy, 1'b0);
        begin_window();
        feed(0, 1'b0, N, 100);
        chk("flush_busy", busy, 1'b1);
        start = 1'b1;
        @(posedge Clk); #1;
        chk("done_state", done, 1'b1);
        @(posedge Clk); #1;
        start = 1'b0;
        chk("no_restart", busy, 1'b0);
        check_window(0);
        chk("stray_start_addr20", mem[20], 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/integral_window_ctrl.md
INTEGRAL_WINDOW_CTRL -- requirements
Module: integral_window_ctrl

Interface
REQ-001 Parameter WIN_W, default 20, window width in pixels.
REQ-002 Parameter WIN_H, default 20, window height in pixels.
REQ-003 Parameter PIX_W, default 8, grayscale pixel width.
REQ-004 Parameter ACC_W, default 32, integral value width; must satisfy ACC_W >= PIX_W + clog2(WIN_W*WIN_H).
REQ-005 Port Clk  input  1  system clock; all logic on rising edge.
REQ-006 Port Reset_n  input  1  asynchronous active-low reset.
REQ-007 Port start  input  1  single-cycle pulse that begins one window.
REQ-008 Port abort  input  1  synchronous cancel of the current window.
REQ-009 Port pix_valid  input  1  pix_data is valid this cycle.
REQ-010 Port pix_ready  output  1  block accepts a pixel this cycle.
REQ-011 Port pix_data  input  PIX_W  pixel, raster order: row-major, column 0 first.
REQ-012 Port ii_we  output  1  integral write strobe.
REQ-013 Port ii_addr  output  clog2(WIN_W*WIN_H)  integral write address, row*WIN_W+col.
REQ-014 Port ii_wdata  output  ACC_W  integral value.
REQ-015 Port row_done  output  1  one-cycle pulse accompanying the write of the last column of each row.
REQ-016 Port busy  output  1  high in LOAD and FLUSH.
REQ-017 Port done  output  1  one-cycle pulse when a window completes.

Function
REQ-018 FSM states: IDLE, LOAD, FLUSH, DONE.
REQ-019 IDLE->LOAD on start; col, row and the running row sum clear to 0 on that transition.
REQ-020 pix_ready = 1 only in LOAD; a pixel is accepted on a cycle where pix_valid && pix_ready.
REQ-021 Per accepted pixel p at (row r, col c): rowsum' = (c==0 ? 0 : rowsum) + p; value = rowsum' + (r==0 ? 0 : prev[c]); prev[c] <= value.
REQ-022 prev is a WIN_W x ACC_W internal register row holding the integral values of the previous row.
REQ-023 Latency: pixel accepted in cycle t -> ii_we=1 with ii_addr, ii_wdata in cycle t+1 (registered outputs), exactly one write per pixel.
REQ-024 No accepted pixel in cycle t -> ii_we=0 in t+1; ii_addr and ii_wdata hold their last values.
REQ-025 col increments per accepted pixel and wraps from WIN_W-1 to 0, incrementing row.
REQ-026 row_done is asserted in the same cycle as the ii_we for col==WIN_W-1.
REQ-027 Acceptance of pixel (WIN_H-1, WIN_W-1) -> FLUSH (1 cycle, emits the final write) -> DONE (done=1 for 1 cycle) -> IDLE.
REQ-028 Arithmetic is unsigned and ACC_W wide; overflow wraps modulo 2^ACC_W with no flag.
REQ-029 start outside IDLE is ignored.
REQ-030 abort in any state -> IDLE next cycle; no done pulse; a write already registered for the abort cycle still appears; no further writes.
REQ-031 If abort and start are high in the same cycle in IDLE, abort wins and the block stays in IDLE.
REQ-032 pix_valid outside LOAD has no effect; pix_data is not sampled.

Reset
REQ-033 Reset_n low asynchronously forces IDLE, and clears col, row, rowsum and prev to 0.
REQ-034 During reset: pix_ready=0, ii_we=0, ii_addr=0, ii_wdata=0, row_done=0, busy=0, done=0.
REQ-035 Reset mid-window discards all progress; the next start begins a fresh window.

Verification
REQ-036 All-ones window, pixel=1 every cycle: write to addr 0 = 1, addr 19 = 20, addr 20 = 2, addr 399 = 400; done exactly 1 cycle after the write to addr 399; 400 writes, 20 row_done pulses.
REQ-037 Ramp pixel = col+1 with pix_valid toggling every other cycle: values match a software integral image; no write in cycles following an idle pixel cycle.
REQ-038 Pixel=255 everywhere, ACC_W=32: addr 399 = 102000; no wrap.
REQ-039 abort after 150 pixels: no write after the abort cycle +1, done never asserted; a new start with pixel=1 everywhere gives addr 0 = 1 (no stale prev/rowsum).
REQ-040 Reset_n pulsed low asynchronously mid-row 7: all outputs 0 immediately; start afterwards reproduces the REQ-036 results.
REQ-041 start pulsed in LOAD, FLUSH and DONE, and start+abort together in IDLE: no state change or restart; write sequence is unaffected.
